// File: rtl/demux_route_ctrl.sv
// Upstream routing control for the 1:16 demux: valid/ready intake,
// fixed-dwell registered route hold, and delivered/dropped status counters.
module demux_route_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_chan,
    input  logic             in_data,
    input  logic [15:0]      chan_en,
    output logic [3:0]       sel,
    output logic             din,
    output logic             route_active,
    output logic [CNT_W-1:0] deliv_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [7:0]       DWELL_LD = 8'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nxt;
    logic [7:0]         dwell, dwell_nxt;
    logic [3:0]         sel_nxt;
    logic               din_nxt;
    logic               act_nxt;
    logic [CNT_W-1:0]   deliv_nxt;
    logic [CNT_W-1:0]   drop_nxt;
    logic               xfer;
    logic               chan_ok;
    logic               load;

    // Ready is only a function of state, never of in_valid.
    assign in_ready = !rst && (state == IDLE || dwell == 8'd0);
    assign xfer     = in_valid && in_ready;
    assign chan_ok  = chan_en[in_chan];
    assign load     = xfer && chan_ok;

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        sel_nxt   = sel;
        din_nxt   = din;
        act_nxt   = route_active;
        deliv_nxt = deliv_cnt;
        drop_nxt  = drop_cnt;

        if (load) begin
            sel_nxt   = in_chan;
            din_nxt   = in_data;
            act_nxt   = 1'b1;
            dwell_nxt = DWELL_LD;
            state_nxt = HOLD;
        end else if (state == HOLD) begin
            if (dwell != 8'd0) begin
                dwell_nxt = dwell - 8'd1;
            end else begin
                din_nxt   = 1'b0;
                act_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        end

        if (load && deliv_cnt != CNT_MAX) begin
            deliv_nxt = deliv_cnt + CNT_ONE;
        end
        if (xfer && !chan_ok && drop_cnt != CNT_MAX) begin
            drop_nxt = drop_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dwell        <= 8'd0;
            sel          <= 4'd0;
            din          <= 1'b0;
            route_active <= 1'b0;
            deliv_cnt    <= '0;
            drop_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            dwell        <= dwell_nxt;
            sel          <= sel_nxt;
            din          <= din_nxt;
            route_active <= act_nxt;
            deliv_cnt    <= deliv_nxt;
            drop_cnt     <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Scoreboard bench for demux_route_ctrl: the driver queues accepted requests,
// a monitor replays them through a cycle-count route model and compares.
module tb_demux_route_ctrl;

    localparam int DW   = 4;
    localparam int MAXA = 255;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_chan;
    logic        in_data;
    logic [15:0] chan_en;
    logic [3:0]  sel;
    logic        din;
    logic        route_active;
    logic [7:0]  deliv_cnt;
    logic [7:0]  drop_cnt;

    logic        b_rst;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_chan;
    logic        b_data;
    logic [3:0]  b_sel;
    logic        b_din;
    logic        b_act;
    logic [1:0]  b_deliv;
    logic [1:0]  b_drop;

    demux_route_ctrl #(.DWELL(DW), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_chan(in_chan), .in_data(in_data), .chan_en(chan_en),
        .sel(sel), .din(din), .route_active(route_active),
        .deliv_cnt(deliv_cnt), .drop_cnt(drop_cnt)
    );

    demux_route_ctrl #(.DWELL(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_chan(b_chan), .in_data(b_data), .chan_en(16'hFFFF),
        .sel(b_sel), .din(b_din), .route_active(b_act),
        .deliv_cnt(b_deliv), .drop_cnt(b_drop)
    );

    typedef struct {
        bit         en;
        logic [3:0] chan;
        logic       data;
    } req_t;

    req_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rmask  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: m_left = visible cycles remaining for the current route.
    int m_left = 0, m_sel = 0, m_din = 0, m_act = 0, m_deliv = 0, m_drop = 0;

    initial begin
        req_t r;
        bit   loaded;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                m_left = 0; m_sel = 0; m_din = 0; m_act = 0;
                m_deliv = 0; m_drop = 0;
                q.delete();
                chk("rst_ready", 32'(in_ready), 0);
            end else begin
                loaded = 0;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    if (r.en) begin
                        loaded = 1;
                        m_left = DW;
                        m_sel  = r.chan;
                        m_din  = r.data;
                        m_act  = 1;
                        if (m_deliv < MAXA) m_deliv++;
                    end else if (m_drop < MAXA) begin
                        m_drop++;
                    end
                end
                if (!loaded) begin
                    if (m_left > 0) m_left--;
                    if (m_left == 0) begin
                        m_act = 0;
                        m_din = 0;
                    end
                end
                chk("in_ready", 32'(in_ready), 32'(m_left <= 1));
            end
            chk("sel", 32'(sel), 32'(m_sel));
            chk("din", 32'(din), 32'(m_din));
            chk("route_active", 32'(route_active), 32'(m_act));
            chk("deliv_cnt", 32'(deliv_cnt), 32'(m_deliv));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rmask) chan_en = 16'($urandom() | $urandom());
        end
    end

    task automatic send(input logic [3:0] c, input logic d);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = c;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout got ready=0 want ready=1 chan %0d", c);
        end else begin
            q.push_back('{en: chan_en[c], chan: c, data: d});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_rst(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        logic [3:0] ec;
        logic       ed;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_chan  = 4'd0;
        in_data  = 1'b0;
        chan_en  = 16'hFFFF;
        b_rst    = 1'b1;
        b_valid  = 1'b0;
        b_chan   = 4'd0;
        b_data   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(4'd9, 1'b1);
        idle(7);

        send(4'd3, 1'b1);
        send(4'd7, 1'b0);
        send(4'd12, 1'b1);
        idle(7);

        do_rst(1);
        chan_en = 16'hFFF7;
        send(4'd3, 1'b1);
        send(4'd4, 1'b1);
        idle(6);
        chan_en = 16'hFFFF;

        send(4'd5, 1'b1);
        idle(1);
        @(negedge clk);
        in_valid = 1'b0;
        chan_en  = 16'hFFDF;
        idle(5);
        chan_en = 16'hFFFF;

        send(4'd5, 1'b1);
        idle(1);
        do_rst(1);
        idle(3);

        rmask = 1;
        repeat (400) begin
            k = $urandom_range(0, 19);
            if (k == 0) do_rst($urandom_range(1, 2));
            else if (k < 6) idle(1);
            else send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        rmask = 0;
        idle(DW + 2);
        chan_en = 16'hFFFF;

        @(negedge clk);
        b_rst   = 1'b0;
        b_valid = 1'b1;
        b_chan  = 4'($urandom_range(0, 15));
        b_data  = 1'($urandom_range(0, 1));
        ec = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            ec = b_chan;
            ed = b_data;
            @(posedge clk);
            #2;
            chk("b_sel", 32'(b_sel), 32'(ec));
            chk("b_din", 32'(b_din), 32'(ed));
            chk("b_active", 32'(b_act), 1);
            chk("b_deliv", 32'(b_deliv), 32'(i < 3 ? i : 3));
            chk("b_ready", 32'(b_ready), 1);
            @(negedge clk);
            b_chan = 4'($urandom_range(0, 15));
            b_data = 1'($urandom_range(0, 1));
        end
        b_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("b_end_active", 32'(b_act), 0);
        chk("b_end_din", 32'(b_din), 0);
        chk("b_end_sel", 32'(b_sel), 32'(ec));
        chk("b_end_deliv", 32'(b_deliv), 3);
        chk("b_drop", 32'(b_drop), 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
